// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: frame strobe, idle/serve/play/point/over FSM,
// miss detection and BCD scoring for both players.
module pong_game_ctrl #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90,
  parameter int unsigned TICK_LINE    = 515,
  parameter int unsigned LEFT_OUT     = 145,
  parameter int unsigned RIGHT_OUT    = 782
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic [9:0]  ballx,
  output logic        ball_hold,
  output logic        ball_step,
  output logic        serve_dir,
  output logic [15:0] score,
  output logic        game_over,
  output logic        winner,
  output logic        paused
);

  localparam int unsigned DW = 10;
  localparam int unsigned CW = 8;
  localparam int unsigned SW = 8;

  localparam logic [SW-1:0] WIN_BCD    = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);
  localparam logic [CW-1:0] POINT_LAST = CW'(POINT_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [SW-1:0] p1_q, p1_n;
  logic [SW-1:0] p2_q, p2_n;
  logic          serve_dir_q, serve_dir_n;
  logic          winner_q, winner_n;
  logic          paused_q, paused_n;
  logic          m_d, tick_q, start_d;

  logic m_c, sp_c, miss_l_c, miss_r_c, scorer_at_win_c;

  // One-digit-pair BCD increment; scores stop at WIN_SCORE so tens never wraps
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign m_c      = (hCount == DW'(0)) && (vCount == DW'(TICK_LINE));
  assign sp_c     = start & ~start_d;
  assign miss_l_c = (ballx <= DW'(LEFT_OUT));
  assign miss_r_c = (ballx >= DW'(RIGHT_OUT));
  // serve_dir records the last scorer: 1 = p1 scored, 0 = p2 scored
  assign scorer_at_win_c = serve_dir_q ? (p1_q == WIN_BCD) : (p2_q == WIN_BCD);

  // Edge detectors for the frame strobe and the start button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_d     <= 1'b0;
      tick_q  <= 1'b0;
      start_d <= 1'b0;
    end else begin
      m_d     <= m_c;
      tick_q  <= m_c & ~m_d;
      start_d <= start;
    end
  end

  // Match state and score registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      serve_dir_q <= 1'b1;
      winner_q    <= 1'b0;
      paused_q    <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      p1_q        <= p1_n;
      p2_q        <= p2_n;
      serve_dir_q <= serve_dir_n;
      winner_q    <= winner_n;
      paused_q    <= paused_n;
    end
  end

  // Next-state, frame counting, scoring and pause logic
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    p1_n        = p1_q;
    p2_n        = p2_q;
    serve_dir_n = serve_dir_q;
    winner_n    = winner_q;
    paused_n    = paused_q;
    case (state_q)
      S_IDLE: begin
        if (sp_c) begin
          p1_n    = '0;
          p2_n    = '0;
          cnt_n   = '0;
          state_n = S_SERVE;
        end
      end
      S_SERVE: begin
        if (tick_q) begin
          if (cnt_q == SERVE_LAST) begin
            cnt_n   = '0;
            state_n = S_PLAY;
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end
      end
      S_PLAY: begin
        if (!paused_q && miss_l_c) begin
          p2_n        = bcd_inc(p2_q);
          serve_dir_n = 1'b0;
          cnt_n       = '0;
          paused_n    = 1'b0;
          state_n     = S_POINT;
        end else if (!paused_q && miss_r_c) begin
          p1_n        = bcd_inc(p1_q);
          serve_dir_n = 1'b1;
          cnt_n       = '0;
          paused_n    = 1'b0;
          state_n     = S_POINT;
        end else if (sp_c) begin
          paused_n = ~paused_q;
        end
      end
      S_POINT: begin
        if (tick_q) begin
          if (cnt_q == POINT_LAST) begin
            cnt_n = '0;
            if (scorer_at_win_c) begin
              winner_n = ~serve_dir_q;
              state_n  = S_OVER;
            end else begin
              state_n = S_SERVE;
            end
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end
      end
      S_OVER: begin
        if (sp_c) begin
          p1_n     = '0;
          p2_n     = '0;
          winner_n = 1'b0;
          cnt_n    = '0;
          state_n  = S_SERVE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Output decode from registered state
  assign ball_hold = (state_q != S_PLAY);
  assign ball_step = (state_q == S_PLAY) & tick_q & ~paused_q;
  assign game_over = (state_q == S_OVER);
  assign serve_dir = serve_dir_q;
  assign winner    = winner_q;
  assign paused    = paused_q;
  assign score     = {p1_q, p2_q};

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: expected output snapshots are queued
// ahead of stimulus; a monitor pops one whenever the observed outputs change.
module tb_pong_game_ctrl;

  localparam int unsigned TL = 515;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  hCount = 10'd1;
  logic [9:0]  vCount = 10'd0;
  logic [9:0]  ballx = 10'd400;
  logic        ball_hold, ball_step, serve_dir, game_over, winner, paused;
  logic [15:0] score;

  pong_game_ctrl #(.WIN_SCORE(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .hCount    (hCount),
    .vCount    (vCount),
    .ballx     (ballx),
    .ball_hold (ball_hold),
    .ball_step (ball_step),
    .serve_dir (serve_dir),
    .score     (score),
    .game_over (game_over),
    .winner    (winner),
    .paused    (paused)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int steps = 0;

  logic [20:0] expq[$];
  logic [20:0] prev = 'x;
  logic [20:0] exp_v;
  wire  [20:0] obs = {score, ball_hold, serve_dir, game_over, winner, paused};

  function automatic logic [20:0] mk(input logic [15:0] s, input logic h, input logic d,
                                     input logic g, input logic w, input logic p);
    return {s, h, d, g, w, p};
  endfunction

  // Monitor: count step pulses and score every output change against the queue
  always @(negedge clk) begin
    if (ball_step === 1'b1) steps++;
    if (obs !== prev) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change got=%h (score,hold,dir,over,win,paused)", obs);
      end else begin
        exp_v = expq.pop_front();
        if (obs !== exp_v) begin
          failures++;
          $display("FAIL output_event got=%h want=%h at %0t", obs, exp_v, $time);
        end
      end
      prev = obs;
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Each frame: pixel counters sit on the strobe position for 3 clocks
  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      hCount = 10'd0;
      vCount = 10'(TL);
      repeat (3) cyc();
      hCount = 10'd1;
      repeat (4) cyc();
    end
  endtask

  task automatic press();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
  endtask

  logic [15:0] p1_tbl [12];

  initial begin
    p1_tbl = '{16'h0101, 16'h0201, 16'h0301, 16'h0401, 16'h0501, 16'h0601,
               16'h0701, 16'h0801, 16'h0901, 16'h1001, 16'h1101, 16'h1201};

    // Reset state
    expq.push_back(mk(16'h0000, 1, 1, 0, 0, 0));
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    // Idle: no motion without a start press
    steps = 0;
    frames(3);
    check("idle_steps", steps, 0);
    check("idle_hold", int'(ball_hold), 1);

    // Serve hold then play
    press();
    steps = 0;
    frames(59);
    check("serve_hold_59", int'(ball_hold), 1);
    expq.push_back(mk(16'h0000, 0, 1, 0, 0, 0));
    frames(1);
    check("serve_steps", steps, 0);
    steps = 0;
    frames(3);
    check("play_steps", steps, 3);

    // Left miss: p2 scores, serve toward the left
    expq.push_back(mk(16'h0001, 1, 0, 0, 0, 0));
    ballx = 10'd140;
    cyc();
    ballx = 10'd400;
    cyc();
    frames(149);
    check("point_serve_hold_149", int'(ball_hold), 1);
    expq.push_back(mk(16'h0001, 0, 0, 0, 0, 0));
    frames(1);

    // Right misses carry p1 through the BCD 9->10 boundary up to 12
    for (int i = 0; i < 12; i++) begin
      expq.push_back(mk(p1_tbl[i], 1, 1, 0, 0, 0));
      ballx = 10'd790;
      cyc();
      ballx = 10'd400;
      cyc();
      if (i < 11) begin
        expq.push_back(mk(p1_tbl[i], 0, 1, 0, 0, 0));
        frames(150);
      end
    end
    expq.push_back(mk(16'h1201, 1, 1, 1, 0, 0));
    frames(90);
    check("over_flag", int'(game_over), 1);
    check("over_winner", int'(winner), 0);

    // Restart from game over
    expq.push_back(mk(16'h0000, 1, 1, 0, 0, 0));
    press();
    expq.push_back(mk(16'h0000, 0, 1, 0, 0, 0));
    frames(60);

    // Pause suppresses stepping and miss detection
    expq.push_back(mk(16'h0000, 0, 1, 0, 0, 1));
    press();
    ballx = 10'd140;
    steps = 0;
    frames(3);
    check("paused_steps", steps, 0);
    check("paused_score", int'(score), 0);
    expq.push_back(mk(16'h0000, 0, 1, 0, 0, 0));
    expq.push_back(mk(16'h0001, 1, 0, 0, 0, 0));
    press();
    ballx = 10'd400;
    expq.push_back(mk(16'h0001, 0, 0, 0, 0, 0));
    frames(150);

    // Asynchronous reset mid-play
    expq.push_back(mk(16'h0000, 1, 1, 0, 0, 0));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_score", int'(score), 0);
    check("async_hold", int'(ball_hold), 1);
    check("async_dir", int'(serve_dir), 1);
    repeat (3) cyc();
    check("queue_empty", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
